// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - dmem_state_e      : FSM state encoding (IDLE / WAIT / DONE)
//   - DEFAULT_BASE_ADDR : byte address of word 0 (.data segment base)
//   - word_index()      : byte address -> word index relative to a base
//   - word_aligned()    : full-word alignment test
//   - span_aligned()    : byte-lane span legality test. Only used when
//                         DMEM_BYTE_LANES_EN is defined.
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

  // Plain 32-bit unsigned subtraction. An address below the base wraps to a
  // huge index, but the top level rejects it separately anyway.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

  function automatic logic word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  // A lane span is legal when it is 1, 2 or 4 contiguous bytes at a naturally
  // aligned lane offset. The byte offset of the address must then be either
  // 0 (word address) or the first enabled lane. An empty span (be == 0) is
  // illegal.
  function automatic logic span_aligned(input logic [3:0] be,
                                        input logic [1:0] off);
    logic       ok;
    logic [1:0] lo;
    ok = 1'b1;
    lo = 2'd0;
    case (be)
      4'b0001: lo = 2'd0;
      4'b0010: lo = 2'd1;
      4'b0100: lo = 2'd2;
      4'b1000: lo = 2'd3;
      4'b0011: lo = 2'd0;
      4'b1100: lo = 2'd2;
      4'b1111: lo = 2'd0;
      default: ok = 1'b0;
    endcase
    return ok && ((off == 2'd0) || (off == lo));
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// -----------------------------------------------------------------------------
// dmem_sram
// Single-port synchronous word array with a registered read and no reset.
// Optional feature macro: DMEM_BYTE_LANES_EN. When it is defined, the array
// adds per-byte write enables.
// Ports:
//   i_clock  in            clock
//   i_re     in            read enable; o_rdata updates on the edge
//   i_we     in            write enable
//   i_addr   in  [AW-1:0]  word address
//   i_wdata  in  [31:0]    write data
//   i_be     in  [3:0]     byte write enables (only when DMEM_BYTE_LANES_EN)
//   o_rdata  out [31:0]    registered read data; holds between reads
// -----------------------------------------------------------------------------
module dmem_sram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          i_clock,
  input  logic          i_re,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
`ifdef DMEM_BYTE_LANES_EN
  input  logic [3:0]    i_be,
`endif
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clock) begin
    if (i_we) begin
`ifdef DMEM_BYTE_LANES_EN
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) begin
          r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
`else
      r_mem[i_addr] <= i_wdata;
`endif
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
// Responder for the CPU data-memory port. It places a word SRAM behind a
// ready/fault handshake with LATENCY programmable wait states.
// Optional feature macro: DMEM_BYTE_LANES_EN. When it is defined, stores use
// byte lanes.
// Ports:
//   clock       in        single clock; all state changes on posedge
//   reset_n     in        asynchronous active-low reset
//   memRead     in        load request, held until ready
//   memWrite    in        store request, held until ready
//   memAddress  in  [31:0] byte address
//   writeValue  in  [31:0] store data
//   byteEnable  in  [3:0]  store byte lanes (only when DMEM_BYTE_LANES_EN)
//   readValue   out [31:0] load data; valid while ready=1, 0 after a fault
//   ready       out       one-cycle completion pulse
//   fault       out       qualifies ready: the request was rejected
// -----------------------------------------------------------------------------
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] memAddress,
  input  logic [31:0] writeValue,
`ifdef DMEM_BYTE_LANES_EN
  input  logic [3:0]  byteEnable,
`endif
  output logic [31:0] readValue,
  output logic        ready,
  output logic        fault
);

  localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  dmem_state_e   r_state, w_state_next;
  logic [3:0]    r_count;
  logic          r_write;
  logic          r_fault;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic          r_rv_valid;
`ifdef DMEM_BYTE_LANES_EN
  logic [3:0]    r_be;
`endif

  logic          w_req;
  logic [31:0]   w_idx;
  logic          w_misalign;
  logic          w_fault;
  logic          w_capture;
  logic          w_enter_done;
  logic          w_fault_at_entry;
  logic          w_sram_re;
  logic          w_sram_we;
  logic [AW-1:0] w_sram_addr;
  logic [31:0]   w_sram_rdata;

  assign w_req = memRead | memWrite;
  assign w_idx = word_index(memAddress, BASE_ADDR);

`ifdef DMEM_BYTE_LANES_EN
  // Stores may cover a naturally aligned sub-word span. Loads always read the
  // full word, so they keep word alignment.
  assign w_misalign = memWrite ? !span_aligned(byteEnable, memAddress[1:0])
                               : !word_aligned(memAddress);
`else
  assign w_misalign = !word_aligned(memAddress);
`endif

  assign w_fault = (memAddress < BASE_ADDR)
                 | (w_idx >= 32'(DEPTH_WORDS))
                 | w_misalign
                 | (memRead & memWrite);

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_enter_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_capture = 1'b1;
          if (LATENCY == 0) begin
            w_state_next = DONE;
            w_enter_done = 1'b1;
          end else begin
            w_state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_count == 4'd0) begin
          w_state_next = DONE;
          w_enter_done = 1'b1;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // With zero wait states, DONE is entered on the capture edge itself. In that
  // case the SRAM must be addressed from the live inputs, not the capture regs.
  assign w_fault_at_entry = (r_state == IDLE) ? w_fault : r_fault;
  assign w_sram_addr      = (r_state == IDLE) ? w_idx[AW-1:0] : r_idx;
  assign w_sram_re        = w_enter_done & ~w_fault_at_entry;
  assign w_sram_we        = (r_state == DONE) & r_write & ~r_fault;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_count    <= 4'd0;
      r_write    <= 1'b0;
      r_fault    <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= 32'd0;
      r_rv_valid <= 1'b0;
`ifdef DMEM_BYTE_LANES_EN
      r_be       <= 4'd0;
`endif
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_count <= CNT_INIT;
        r_write <= memWrite;
        r_fault <= w_fault;
        r_idx   <= w_idx[AW-1:0];
        r_wdata <= writeValue;
`ifdef DMEM_BYTE_LANES_EN
        r_be    <= byteEnable;
`endif
      end else if ((r_state == WAIT) && (r_count != 4'd0)) begin
        r_count <= r_count - 4'd1;
      end
      // readValue follows the SRAM read register only after a clean entry.
      // The SRAM has no reset, so this flag also forces 0 after reset.
      if (w_enter_done) begin
        r_rv_valid <= ~w_fault_at_entry;
      end
    end
  end

  dmem_sram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_sram (
    .i_clock (clock),
    .i_re    (w_sram_re),
    .i_we    (w_sram_we),
    .i_addr  (w_sram_addr),
    .i_wdata (r_wdata),
`ifdef DMEM_BYTE_LANES_EN
    .i_be    (r_be),
`endif
    .o_rdata (w_sram_rdata)
  );

  assign ready     = (r_state == DONE);
  assign fault     = (r_state == DONE) & r_fault;
  assign readValue = r_rv_valid ? w_sram_rdata : 32'd0;

endmodule

// File: tb/tb_data_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_data_memory_responder
// Drives three responders (LATENCY 0, 1 and 3) from a shared clock.
// The bench runs a directed vector table, then hand-written reset-abort
// sequences, then randomized traffic. Results are checked against an array
// model of memory contents and the window/alignment rules.
// -----------------------------------------------------------------------------
module tb_data_memory_responder;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 1024;
  localparam int          NI    = 3;

  logic        clk = 1'b0;
  logic        rst_n [NI];
  logic        mrd   [NI];
  logic        mwr   [NI];
  logic [31:0] maddr [NI];
  logic [31:0] wval  [NI];
  logic [31:0] rval  [NI];
  logic        rdy   [NI];
  logic        flt   [NI];
`ifdef DMEM_BYTE_LANES_EN
  logic [3:0]  be    [NI];
`endif

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    data_memory_responder #(
      .BASE_ADDR   (BASE),
      .DEPTH_WORDS (DEPTH),
      .LATENCY     ((gi == 0) ? 0 : ((gi == 1) ? 1 : 3))
    ) u_dut (
      .clock      (clk),
      .reset_n    (rst_n[gi]),
      .memRead    (mrd[gi]),
      .memWrite   (mwr[gi]),
      .memAddress (maddr[gi]),
      .writeValue (wval[gi]),
`ifdef DMEM_BYTE_LANES_EN
      .byteEnable (be[gi]),
`endif
      .readValue  (rval[gi]),
      .ready      (rdy[gi]),
      .fault      (flt[gi])
    );
  end

  int total = 0;
  int bad   = 0;

  // Reference state: word contents plus whether each word has a known value.
  logic [31:0] model_mem   [NI][DEPTH];
  bit          model_known [NI][DEPTH];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          ef;
    bit          chk_rv;
    logic [31:0] erv;
  } vec_t;

  vec_t vt [14];

  function automatic int lat_of(int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  // Fault rule written directly against the byte window.
  function automatic bit exp_fault(bit rd, bit wr, logic [31:0] a);
    logic [31:0] lim;
    lim = BASE + 32'(4 * DEPTH);
    return (rd && wr) || (a < BASE) || (a >= lim) || (a[1:0] != 2'b00);
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  task automatic drop(int k);
    mrd[k]   = 1'b0;
    mwr[k]   = 1'b0;
    maddr[k] = 32'd0;
    wval[k]  = 32'd0;
  endtask

  // Runs one handshake.
  // The request is presented before an edge and held through the DONE cycle.
  // It is dropped just after the edge that ends DONE.
  task automatic txn(int k, bit rd, bit wr, logic [31:0] a, logic [31:0] wd,
                     output bit seen, output logic [31:0] got_rv,
                     output logic got_flt);
    int n;
    int extra;
    int L;
    L = lat_of(k);
    seen = 1'b0;
    got_rv = 32'd0;
    got_flt = 1'b0;
    @(negedge clk);
    mrd[k] = rd; mwr[k] = wr; maddr[k] = a; wval[k] = wd;
    n = 0;
    while (n < 40 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (rdy[k] === 1'b1) seen = 1'b1;
    end
    check($sformatf("k%0d ready_seen a=%h", k, a), 32'(seen), 32'd1);
    if (!seen) begin
      drop(k);
      return;
    end
    check($sformatf("k%0d latency a=%h", k, a), 32'(n), 32'(L + 1));
    got_rv  = rval[k];
    got_flt = flt[k];
    @(posedge clk); #1;
    check($sformatf("k%0d single_pulse a=%h", k, a), 32'(rdy[k]), 32'd0);
    drop(k);
    extra = 0;
    for (int i = 0; i < L + 2; i++) begin
      @(posedge clk); #1;
      if (rdy[k] === 1'b1) extra++;
    end
    check($sformatf("k%0d no_reaccept a=%h", k, a), 32'(extra), 32'd0);
  endtask

  // Checks one transaction against the model, then updates the model.
  task automatic do_model(int k, bit rd, bit wr, logic [31:0] a, logic [31:0] wd);
    bit          seen;
    logic [31:0] rv;
    logic        f;
    bit          ef;
    int          idx;
    ef = exp_fault(rd, wr, a);
    txn(k, rd, wr, a, wd, seen, rv, f);
    if (!seen) return;
    check($sformatf("k%0d fault rd=%0d wr=%0d a=%h", k, rd, wr, a), 32'(f), 32'(ef));
    if (ef) begin
      check($sformatf("k%0d fault_rv0 a=%h", k, a), rv, 32'd0);
    end else begin
      idx = int'((a - BASE) >> 2);
      if (rd && model_known[k][idx])
        check($sformatf("k%0d load a=%h", k, a), rv, model_mem[k][idx]);
      if (wr) begin
        model_mem[k][idx]   = wd;
        model_known[k][idx] = 1'b1;
      end
    end
  endtask

  task automatic run_table(int k);
    bit          seen;
    logic [31:0] rv;
    logic        f;
    int          idx;
    for (int i = 0; i < 14; i++) begin
      txn(k, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd, seen, rv, f);
      if (seen) begin
        check($sformatf("k%0d vec%0d fault", k, i), 32'(f), 32'(vt[i].ef));
        if (vt[i].chk_rv)
          check($sformatf("k%0d vec%0d rv", k, i), rv, vt[i].erv);
      end
      if (!vt[i].ef && vt[i].wr) begin
        idx = int'((vt[i].addr - BASE) >> 2);
        model_mem[k][idx]   = vt[i].wd;
        model_known[k][idx] = 1'b1;
      end
    end
  endtask

  // Store captured, then reset while the counter is still running.
  task automatic reset_in_wait(int k);
    int cnt;
    @(negedge clk);
    mwr[k] = 1'b1; maddr[k] = 32'h1001_0004; wval[k] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n[k] = 1'b0;
    drop(k);
    #1;
    check($sformatf("k%0d rst_wait rv", k), rval[k], 32'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rdy[k] === 1'b1) cnt++;
    end
    check($sformatf("k%0d rst_wait no_ready", k), 32'(cnt), 32'd0);
    @(negedge clk);
    rst_n[k] = 1'b1;
    do_model(k, 1'b1, 1'b0, 32'h1001_0004, 32'd0);
  endtask

  // Store reaches DONE, then reset before the edge that would commit it.
  task automatic reset_in_done(int k);
    int n;
    @(negedge clk);
    mwr[k] = 1'b1; maddr[k] = 32'h1001_0004; wval[k] = 32'h0BAD_BEEF;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (rdy[k] !== 1'b1 && n < 40);
    check($sformatf("k%0d rst_done reached", k), 32'(rdy[k]), 32'd1);
    #2;
    rst_n[k] = 1'b0;
    drop(k);
    #1;
    check($sformatf("k%0d rst_done ready_low", k), 32'(rdy[k]), 32'd0);
    check($sformatf("k%0d rst_done fault_low", k), 32'(flt[k]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n[k] = 1'b1;
    do_model(k, 1'b1, 1'b0, 32'h1001_0004, 32'd0);
  endtask

  int word_set [16] = '{0, 1, 2, 3, 5, 8, 13, 100, 511, 512, 700, 1000,
                        1020, 1021, 1022, 1023};

  initial begin
    vt[0]  = '{0, 1, 32'h1001_0004, 32'h1234_5678, 0, 0, 32'd0};
    vt[1]  = '{1, 0, 32'h1001_0004, 32'd0,         0, 1, 32'h1234_5678};
    vt[2]  = '{0, 1, 32'h1001_0FFC, 32'hDEAD_BEEF, 0, 0, 32'd0};
    vt[3]  = '{1, 0, 32'h1001_0FFC, 32'd0,         0, 1, 32'hDEAD_BEEF};
    vt[4]  = '{1, 0, 32'h1001_1000, 32'd0,         1, 1, 32'd0};
    vt[5]  = '{0, 1, 32'h1001_0000, 32'hA5A5_A5A5, 0, 0, 32'd0};
    vt[6]  = '{0, 1, 32'h1001_0002, 32'hFFFF_FFFF, 1, 1, 32'd0};
    vt[7]  = '{1, 0, 32'h1001_0000, 32'd0,         0, 1, 32'hA5A5_A5A5};
    vt[8]  = '{1, 1, 32'h1001_0004, 32'd0,         1, 1, 32'd0};
    vt[9]  = '{1, 0, 32'h1001_0004, 32'd0,         0, 1, 32'h1234_5678};
    vt[10] = '{1, 0, 32'h1000_FFFC, 32'd0,         1, 1, 32'd0};
    vt[11] = '{0, 1, 32'h1001_1000, 32'h5555_5555, 1, 1, 32'd0};
    vt[12] = '{1, 0, 32'h1001_0FFC, 32'd0,         0, 1, 32'hDEAD_BEEF};
    vt[13] = '{1, 0, 32'h1001_0001, 32'd0,         1, 1, 32'd0};

    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0;
      drop(k);
`ifdef DMEM_BYTE_LANES_EN
      be[k] = 4'hF;
`endif
      for (int w = 0; w < DEPTH; w++) begin
        model_mem[k][w]   = 32'd0;
        model_known[k][w] = 1'b0;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("k%0d reset ready", k), 32'(rdy[k]), 32'd0);
      check($sformatf("k%0d reset fault", k), 32'(flt[k]), 32'd0);
      check($sformatf("k%0d reset rv", k), rval[k], 32'd0);
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;

    for (int k = 0; k < NI; k++) run_table(k);

    reset_in_wait(2);
    reset_in_done(2);
    reset_in_done(1);
    reset_in_done(0);

`ifdef DMEM_BYTE_LANES_EN
    do_model(1, 1'b0, 1'b1, 32'h1001_0040, 32'h1122_3344);
    be[1] = 4'b0011;
    begin
      bit seen; logic [31:0] rv; logic f;
      txn(1, 1'b0, 1'b1, 32'h1001_0040, 32'hAABB_CCDD, seen, rv, f);
      check("k1 lanes store fault", 32'(f), 32'd0);
      be[1] = 4'b0000;
      txn(1, 1'b0, 1'b1, 32'h1001_0040, 32'h0, seen, rv, f);
      check("k1 lanes be0 fault", 32'(f), 32'd1);
      be[1] = 4'hF;
      txn(1, 1'b1, 1'b0, 32'h1001_0040, 32'h0, seen, rv, f);
      check("k1 lanes load", rv, 32'h1122_CCDD);
    end
    model_mem[1][16] = 32'h1122_CCDD;
`endif

    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 16; i++)
        do_model(k, 1'b0, 1'b1, BASE + 32'(4 * word_set[i]), $urandom);
      for (int i = 0; i < 50; i++) begin
        int          sel;
        int          op;
        logic [31:0] a;
        bit          rd;
        bit          wr;
        sel = $urandom_range(0, 9);
        a   = BASE + 32'(4 * word_set[$urandom_range(0, 15)]);
        if (sel == 7)      a = a + 32'($urandom_range(1, 3));
        else if (sel == 8) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
        else if (sel == 9) a = BASE - 32'(4 * $urandom_range(1, 4));
        op = $urandom_range(0, 19);
        rd = (op < 9) || (op >= 18);
        wr = (op >= 9);
        do_model(k, rd, wr, a, $urandom);
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
